// File: rtl/core_pkg.sv
// Shared core types: fetch FSM states and the PC/branch-target width used by
// pc_fetch and the branch-target lookup table.
package core_pkg;

    localparam int unsigned CORE_PC_W = 10;

    typedef logic [CORE_PC_W-1:0] pc_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/cycle_counter.sv
// Saturating up-counter with synchronous clear (priority) and count enable.
module cycle_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pc_fetch.sv
// Program counter and fetch sequencing: IDLE/RUN/DONE control, next-PC
// selection (halt > stall > branch > increment) and the RUN cycle counter.
module pc_fetch
    import core_pkg::*;
#(
    parameter int unsigned            PC_W       = CORE_PC_W,
    parameter logic [PC_W-1:0]        START_ADDR = '0,
    parameter int unsigned            CNT_W      = 16
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic             Halt,
    input  logic             Stall,
    input  logic             BranchTaken,
    input  logic [PC_W-1:0]  Target,
    output logic [PC_W-1:0]  PC,
    output logic             Running,
    output logic             Done,
    output logic [CNT_W-1:0] CycleCount
);

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic              cnt_clr, cnt_en;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (Start) begin
                    state_d = ST_RUN;
                    pc_d    = START_ADDR;
                    cnt_clr = 1'b1;
                end
            end
            ST_RUN: begin
                // Every RUN edge counts, including stalled and halting edges.
                cnt_en = 1'b1;
                if (Halt) begin
                    state_d = ST_DONE;
                end else if (Stall) begin
                    pc_d = pc_q;
                end else if (BranchTaken) begin
                    pc_d = Target;
                end else begin
                    pc_d = pc_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                pc_d    = START_ADDR;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
            pc_q    <= START_ADDR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    cycle_counter #(
        .W (CNT_W)
    ) u_cycle_counter (
        .clk_i   (Clk),
        .rst_ni  (Reset_n),
        .clr_i   (cnt_clr),
        .en_i    (cnt_en),
        .count_o (CycleCount)
    );

    assign PC      = pc_q;
    assign Running = (state_q == ST_RUN);
    assign Done    = (state_q == ST_DONE);

endmodule
